call_stack_unit: RTL and testbench
==================================

# call_stack_unit

Parametrised hardware call/return stack for the multicycle RISC core, the successor to the fixed-size return-address stack. It holds return addresses (or any DATA_W-bit word) pushed on CALL and popped on RET. It exposes the top-of-stack combinationally so the PC source mux can select it in the same cycle as the pop. It adds configurable width and depth, occupancy count, simultaneous push/pop replace, flush, sticky overflow/underflow error flags, and an optional circular-overwrite mode.

## Interface
- DATA_W, 32, width of each stack entry
- DEPTH, 16, number of entries; any integer ≥ 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- sysClk  in  1  system clock, all state updates on rising edge
- sysRstN  in  1  asynchronous active-low reset
- push  in  1  push pushData this cycle
- pop  in  1  pop top entry this cycle
- flush  in  1  synchronous clear of all entries
- clearErr  in  1  synchronous clear of sticky error flags
- pushData  in  DATA_W  word to push (normally PC+1)
- topData  out  DATA_W  current top-of-stack; 0 when empty
- count  out  CNT_W  current occupancy, 0..DEPTH
- isStackEmpty  out  1  count == 0
- isStackFull  out  1  count == DEPTH
- overflowErr  out  1  sticky: a push hit a full stack (non-replace)
- underflowErr  out  1  sticky: a pop hit an empty stack

## Operation
- Storage: DEPTH×DATA_W register array; pointer sp (next free slot), mod DEPTH; count register. Array itself not reset.
- topData = mem[(sp−1) mod DEPTH] when count>0, else 0. Combinational from registered state.
- Priority per edge: flush > push/pop. flush: sp←0, count←0; push/pop that cycle ignored, no error raised.
- push only, not full: mem[sp]←pushData, sp←sp+1, count+1.
- pop only, not empty: sp←sp−1, count−1.
- push & pop, not empty: mem[sp−1]←pushData (replace TOS); sp, count unchanged; no error even when full.
- push & pop, empty: pop ignored, underflowErr set, push performed (count→1).
- pop only, empty: no state change, underflowErr set.
- push only, full: see Configuration.
- Sticky flags: set by their error condition, cleared only by clearErr or reset; if clearErr and a new error coincide, set wins.
- Pointer arithmetic wraps modulo DEPTH (explicit compare, DEPTH need not be power of two).

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): sp=0, count=0, isStackEmpty=1, isStackFull=0, topData=0, overflowErr=0, underflowErr=0.
- Reset mid-operation: all state above forced immediately; array contents become don't-care and are never visible (topData masked by empty).
- Push latency 1: value pushed at edge N appears on topData after edge N.
- Pop: topData valid during the pop cycle (consumer samples it before the edge); next entry visible after edge.
- count, isStackEmpty, isStackFull, error flags all update at the same edge as the causing operation.
- No handshake/stall: push and pop accepted every cycle; no back-to-back restrictions.

## Configuration
- STACK_WRAP_EN defined: push only when full overwrites the oldest entry (mem[sp]←pushData, sp←sp+1, count stays DEPTH) and sets overflowErr; the most recent DEPTH entries remain poppable in LIFO order.
- STACK_WRAP_EN undefined: push only when full is dropped; no state change except overflowErr set.

## Test plan
- Reset, then push 0x10,0x20,0x30 on consecutive cycles -> topData 0x30, count 3; three pops return 0x30,0x20,0x10, then isStackEmpty=1, topData=0.
- DEPTH=4: push 1..4 -> isStackFull=1; push 5 without macro -> count 4, topData 4, overflowErr=1; with STACK_WRAP_EN -> topData 5, pops give 5,4,3,2 then empty.
- Push 0xA then push&pop 0xB same cycle -> count 1, topData 0xB; on full stack push&pop -> count DEPTH, no overflowErr.
- Pop on empty -> underflowErr=1, count 0; clearErr with simultaneous pop on empty -> underflowErr stays 1; clearErr alone -> 0.
- Push 3 entries, assert flush with push=1 -> count 0, topData 0, no error; push&pop on empty -> count 1, underflowErr=1.
- Push 2 entries, assert sysRstN=0 between edges -> count 0, isStackEmpty=1, topData 0 immediately, before next edge.

Source files
------------

// File: rtl/call_stack_unit_if.sv
// Push/pop request and stack status bundle for call_stack_unit.
// master drives requests (the core), slave is the stack itself.
interface call_stack_unit_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              flush;
    logic              clearErr;
    logic [DATA_W-1:0] pushData;
    logic [DATA_W-1:0] topData;
    logic [CNT_W-1:0]  count;
    logic              isStackEmpty;
    logic              isStackFull;
    logic              overflowErr;
    logic              underflowErr;

    modport master (
        output push, pop, flush, clearErr, pushData,
        input  topData, count, isStackEmpty, isStackFull, overflowErr, underflowErr
    );

    modport slave (
        input  push, pop, flush, clearErr, pushData,
        output topData, count, isStackEmpty, isStackFull, overflowErr, underflowErr
    );
endinterface

// File: rtl/call_stack_unit.sv
// Call/return stack with combinational top-of-stack, replace, flush and sticky errors.
// Define STACK_WRAP_EN to let a push on a full stack overwrite the oldest entry.
module call_stack_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic              sysClk,
    input logic              sysRstN,
    call_stack_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  sp_q, sp_d, sp_inc, sp_dec;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              empty, full;

    // Explicit wrap so DEPTH need not be a power of two.
    assign sp_inc = (sp_q == PTR_W'(DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
    assign sp_dec = (sp_q == '0) ? PTR_W'(DEPTH - 1) : sp_q - PTR_W'(1);
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~bus.clearErr;
        unf_d   = unf_q & ~bus.clearErr;
        wr_en   = 1'b0;
        wr_addr = sp_q;
        if (bus.flush) begin
            sp_d    = '0;
            count_d = '0;
        end else if (bus.push && bus.pop) begin
            wr_en = 1'b1;
            if (!empty) begin
                wr_addr = sp_dec;
            end else begin
                unf_d   = 1'b1;
                sp_d    = sp_inc;
                count_d = CNT_W'(1);
            end
        end else if (bus.push) begin
            if (!full) begin
                wr_en   = 1'b1;
                sp_d    = sp_inc;
                count_d = count_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef STACK_WRAP_EN
                // Oldest entry sits at sp when full; count stays at DEPTH.
                wr_en = 1'b1;
                sp_d  = sp_inc;
`endif
            end
        end else if (bus.pop) begin
            if (!empty) begin
                sp_d    = sp_dec;
                count_d = count_q - CNT_W'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysRstN) begin
        if (!sysRstN) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never reset; stale contents stay hidden behind the empty mask.
    always_ff @(posedge sysClk) begin
        if (wr_en) mem_q[wr_addr] <= bus.pushData;
    end

    assign bus.topData      = empty ? '0 : mem_q[sp_dec];
    assign bus.count        = count_q;
    assign bus.isStackEmpty = empty;
    assign bus.isStackFull  = full;
    assign bus.overflowErr  = ovf_q;
    assign bus.underflowErr = unf_q;
endmodule

// File: tb/tb_call_stack_unit.sv
// Directed + random bench for call_stack_unit against a queue-based stack model.
module tb_call_stack_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic sysClk  = 1'b0;
    logic sysRstN = 1'b0;
    always #5 sysClk = ~sysClk;

    call_stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    call_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sysClk (sysClk),
        .sysRstN(sysRstN),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] mq[$];
    bit m_ovf = 0, m_unf = 0;

    function automatic logic [DATA_W-1:0] m_top();
        if (mq.size() == 0) return '0;
        return mq[mq.size() - 1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), mq.size());
        chk({tag, ".top"},   bus.topData, m_top());
        chk({tag, ".empty"}, 32'(bus.isStackEmpty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(bus.isStackFull), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflowErr), 32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.underflowErr), 32'(m_unf));
    endtask

    // Stack semantics as a plain LIFO queue; back of queue is top of stack.
    task automatic model(input bit ps, input bit pp, input bit fl, input bit ce,
                         input logic [DATA_W-1:0] d);
        bit n_ovf = 0, n_unf = 0;
        if (fl) begin
            mq.delete();
        end else if (ps && pp) begin
            if (mq.size() > 0) mq[mq.size() - 1] = d;
            else begin n_unf = 1; mq.push_back(d); end
        end else if (ps) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else begin
                n_ovf = 1;
`ifdef STACK_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(d);
`endif
            end
        end else if (pp) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else n_unf = 1;
        end
        m_ovf = (m_ovf && !ce) || n_ovf;
        m_unf = (m_unf && !ce) || n_unf;
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks both sides of the edge.
    task automatic step(input string tag, input bit ps, input bit pp, input bit fl,
                        input bit ce, input logic [DATA_W-1:0] d);
        bus.push = ps; bus.pop = pp; bus.flush = fl; bus.clearErr = ce; bus.pushData = d;
        #1;
        chk({tag, ".pre_top"}, bus.topData, m_top());
        model(ps, pp, fl, ce, d);
        @(posedge sysClk);
        #1;
        bus.push = 0; bus.pop = 0; bus.flush = 0; bus.clearErr = 0;
        chk_all(tag);
    endtask

    initial begin
        bus.push = 0; bus.pop = 0; bus.flush = 0; bus.clearErr = 0; bus.pushData = '0;
        #3;
        chk_all("reset");
        @(negedge sysClk);
        sysRstN = 1'b1;
        @(posedge sysClk);
        #1;

        step("push10", 1, 0, 0, 0, 32'h10);
        step("push20", 1, 0, 0, 0, 32'h20);
        step("push30", 1, 0, 0, 0, 32'h30);
        chk("lifo.top", bus.topData, 32'h30);
        chk("lifo.count", 32'(bus.count), 3);
        step("pop30", 0, 1, 0, 0, '0);
        step("pop20", 0, 1, 0, 0, '0);
        step("pop10", 0, 1, 0, 0, '0);
        chk("lifo.empty", 32'(bus.isStackEmpty), 1);
        chk("lifo.top0", bus.topData, 0);

        for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, 0, 32'(i));
        chk("fill.full", 32'(bus.isStackFull), 1);
        step("push_full", 1, 0, 0, 0, 32'h5);
        chk("push_full.ovf", 32'(bus.overflowErr), 1);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 0, '0);
        chk("drain.empty", 32'(bus.isStackEmpty), 1);
        step("clr_ovf", 0, 0, 0, 1, '0);

        step("pushA", 1, 0, 0, 0, 32'hA);
        step("replB", 1, 1, 0, 0, 32'hB);
        chk("replB.top", bus.topData, 32'hB);
        chk("replB.count", 32'(bus.count), 1);
        for (int i = 0; i < 3; i++) step("fill2", 1, 0, 0, 0, 32'h100 + 32'(i));
        step("repl_full", 1, 1, 0, 0, 32'hC);
        chk("repl_full.ovf", 32'(bus.overflowErr), 0);
        chk("repl_full.top", bus.topData, 32'hC);
        step("flush1", 0, 0, 1, 0, '0);

        step("pop_empty", 0, 1, 0, 0, '0);
        chk("pop_empty.unf", 32'(bus.underflowErr), 1);
        step("clr_pop_empty", 0, 1, 0, 1, '0);
        chk("clr_pop.unf", 32'(bus.underflowErr), 1);
        step("clr_only", 0, 0, 0, 1, '0);
        chk("clr_only.unf", 32'(bus.underflowErr), 0);

        for (int i = 0; i < 3; i++) step("pre_flush", 1, 0, 0, 0, 32'h200 + 32'(i));
        step("flush_push", 1, 0, 1, 0, 32'hDEAD);
        chk("flush_push.count", 32'(bus.count), 0);
        chk("flush_push.ovf", 32'(bus.overflowErr), 0);
        step("pp_empty", 1, 1, 0, 0, 32'h77);
        chk("pp_empty.count", 32'(bus.count), 1);
        chk("pp_empty.unf", 32'(bus.underflowErr), 1);

        step("clr2", 0, 0, 0, 1, '0);
        step("flush2", 0, 0, 1, 0, '0);
        step("rst_push1", 1, 0, 0, 0, 32'h300);
        step("rst_push2", 1, 0, 0, 0, 32'h301);
        #1;
        sysRstN = 1'b0;
        #1;
        mq.delete(); m_ovf = 0; m_unf = 0;
        chk_all("mid_reset");
        @(negedge sysClk);
        sysRstN = 1'b1;
        @(posedge sysClk);
        #1;

        for (int i = 0; i < 400; i++) begin
            bit ps, pp, fl, ce;
            ps = 1'($urandom_range(0, 1));
            pp = 1'($urandom_range(0, 2) == 0);
            fl = 1'($urandom_range(0, 15) == 0);
            ce = 1'($urandom_range(0, 7) == 0);
            step("rand", ps, pp, fl, ce, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
